conversor_bcd: RTL and testbench
================================

# conversor_bcd

Sequential binary-to-BCD converter that sits directly downstream of the shift-add multiplier. It captures the 9-bit product when the multiplier signals completion and converts it to three BCD digits (hundreds, tens, units) using the shift-add-3 (double-dabble) algorithm, one bit per clock. The digits drive the board's 7-segment display decoders. The block uses the same start/done/idle handshake as the multiplier.

## Interface
- LARGURA, 9: binary input width; matches the multiplier product width.
- DIGITOS, 3: number of BCD output digits; requires 10^DIGITOS > 2^LARGURA − 1.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- st  in  1  start; driven by the multiplier `done`.
- binario  in  LARGURA  value to convert; driven by multiplier `produto`.
- done  out  1  conversion-complete strobe; high for exactly one cycle.
- idle  out  1  high when a new `st` will be accepted.
- centena  out  4  hundreds digit, registered.
- dezena  out  4  tens digit, registered.
- unidade  out  4  units digit, registered.

## Operation
- FSM states:
  - OCIOSO: idle=1.
  - CONVERTE: idle=0, done=0.
  - FIM: done=1, idle=0.
- OCIOSO with st=1:
  - load binario into the low LARGURA bits of a (4·DIGITOS + LARGURA)-bit shift register, 21 bits by default.
  - clear the BCD field and the iteration counter.
  - go to CONVERTE.
- OCIOSO with st=0: hold.
- CONVERTE, each cycle: combinational adjust, then shift.
  - Adjust: every BCD nibble ≥ 5 gets +3, computed mod 16.
  - Shift: the whole register shifts left by 1, with 0 entering the LSB.
  - The counter increments.
  - After step LARGURA (9): copy the BCD nibbles to centena/dezena/unidade and go to FIM.
- FIM: one cycle, then return to OCIOSO unconditionally.
- st is ignored in CONVERTE and FIM: no queueing, no restart.
- binario is sampled only on the accepting edge. Later changes to binario have no effect.
- Digit outputs hold the last result until the next conversion completes. They are not cleared at start.
- Range: the maximum input of 511 gives 5/1/1. No nibble ever exceeds 9 after the final shift.

## Timing
- Reset values, forced asynchronously by rst_n=0:
  - state=OCIOSO, idle=1, done=0.
  - centena=dezena=unidade=0.
  - shift register and counter = 0.
- Reset mid-conversion aborts the conversion; no done is produced and the outputs are the reset values.
- Latency, with st accepted at edge E:
  - Conversion steps run at edges E+1 … E+9.
  - Digits become valid at edge E+9.
  - done is high in the cycle between edges E+9 and E+10.
  - idle returns high after edge E+10.
- Minimum spacing between accepted starts: 11 cycles.
- st=1 coinciding with rst_n deassertion: the start is accepted only at the first rising edge with rst_n=1 and st=1.
- st held high continuously: a new conversion starts at every OCIOSO cycle, so one conversion every 11 cycles.
- done and idle are never high simultaneously.

## Structure
- Package conversor_bcd_pkg holds:
  - the state enum (OCIOSO, CONVERTE, FIM);
  - localparams for default LARGURA=9 and DIGITOS=3;
  - counter width $clog2(LARGURA+1).
- Sub-module ajuste_bcd: purely combinational; 4-bit in, 4-bit out; adds 3 when the input is ≥ 5. It is instantiated DIGITOS times via generate.
- The top level contains the FSM, the counter, the shift register and the output registers.

## Test plan
- Reset: assert rst_n=0 mid-cycle, with no clock edge → outputs go to 0/0/0 immediately, idle=1, done=0.
- Single conversion: binario=143 (13×11), st pulse → done exactly 10 edges after acceptance; digits 1/4/3; idle high one cycle later.
- Second conversion: binario=105 (7×15) → 1/0/5. Before that done, the outputs still show 1/4/3.
- Boundaries: binario=0 → 0/0/0; binario=511 → 5/1/1; binario=99 → 0/9/9; binario=100 → 1/0/0.
- Ignored start and input change: st pulses and a change of binario to 7 during CONVERTE → the result still matches the originally captured value; no extra done.
- Abort: rst_n low at the 5th conversion step → outputs 0/0/0, no done. After release, a new st with binario=225 → 2/2/5.

Source files
------------

// File: rtl/conversor_bcd_pkg.sv
// conversor_bcd_pkg
// Shared definitions for the binary-to-BCD converter that sits after the
// shift-add multiplier: default widths, counter width and the FSM state type.
package conversor_bcd_pkg;

    // Default binary width (multiplier product) and number of BCD digits.
    localparam int LARGURA_PADRAO = 9;
    localparam int DIGITOS_PADRAO = 3;

    // Iteration counter must be able to count up to LARGURA steps.
    localparam int LARGURA_CONT = $clog2(LARGURA_PADRAO + 1);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        FIM      = 2'd2
    } estado_t;

endpackage

// File: rtl/conversor_bcd_if.sv
// conversor_bcd_if
// Start/done/idle handshake plus data bus of the converter.
//   st       : start pulse (multiplier done)
//   binario  : value to convert (multiplier product)
//   done     : one-cycle completion strobe
//   idle     : converter will accept a new st
//   centena/dezena/unidade : registered BCD digits
// master = producer/consumer side, slave = the converter itself.
interface conversor_bcd_if
    import conversor_bcd_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) ();

    logic               st;
    logic [LARGURA-1:0] binario;
    logic               done;
    logic               idle;
    logic [3:0]         centena;
    logic [3:0]         dezena;
    logic [3:0]         unidade;

    modport master (
        output st,
        output binario,
        input  done,
        input  idle,
        input  centena,
        input  dezena,
        input  unidade
    );

    modport slave (
        input  st,
        input  binario,
        output done,
        output idle,
        output centena,
        output dezena,
        output unidade
    );

endinterface

// File: rtl/conversor_bcd_ajuste.sv
// ajuste_bcd
// Double-dabble correction for one BCD nibble: adds 3 when the nibble is 5
// or more so that the following left shift carries correctly into the next
// decimal digit. Purely combinational.
//   entrada : nibble before correction
//   saida   : corrected nibble (mod 16)
module ajuste_bcd (
    input  logic [3:0] entrada,
    output logic [3:0] saida
);

    assign saida = (entrada >= 4'd5) ? entrada + 4'd3 : entrada;

endmodule

// File: rtl/conversor_bcd.sv
// conversor_bcd
// Sequential binary-to-BCD converter (shift-add-3), one bit per clock.
// A start captures binario into the low bits of a shift register whose upper
// bits hold the BCD digits; after LARGURA adjust+shift steps the digits are
// copied to the registered outputs and done pulses for one cycle.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : slave side of the start/done/idle handshake and data
module conversor_bcd
    import conversor_bcd_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO,
    parameter int DIGITOS = DIGITOS_PADRAO
) (
    input  logic           clk,
    input  logic           rst_n,
    conversor_bcd_if.slave bus
);

    localparam int                LARGURA_REG = 4 * DIGITOS + LARGURA;
    localparam int                CW          = $clog2(LARGURA + 1);
    localparam logic [CW-1:0]     ULTIMO      = CW'(LARGURA - 1);

    estado_t                  estado;
    estado_t                  proximo;
    logic [LARGURA_REG-1:0]   desloc;
    logic [LARGURA_REG-1:0]   ajustado;
    logic [LARGURA_REG-1:0]   deslocado;
    logic [CW-1:0]            contador;
    logic                     carrega;
    logic                     passo;
    logic                     ultimo;
    logic                     done_c;
    logic                     idle_c;

    // One correction cell per BCD nibble; the binary part passes untouched.
    assign ajustado[LARGURA-1:0] = desloc[LARGURA-1:0];

    for (genvar i = 0; i < DIGITOS; i++) begin : g_ajuste
        ajuste_bcd u_ajuste (
            .entrada (desloc[LARGURA + 4*i +: 4]),
            .saida   (ajustado[LARGURA + 4*i +: 4])
        );
    end

    assign deslocado = ajustado << 1;

    // Next-state and handshake decode. The final step is the one taken while
    // the counter already shows LARGURA-1, so the result of that step is what
    // lands in the digit registers.
    always_comb begin
        proximo = estado;
        carrega = 1'b0;
        passo   = 1'b0;
        ultimo  = 1'b0;
        done_c  = 1'b0;
        idle_c  = 1'b0;
        case (estado)
            OCIOSO: begin
                idle_c = 1'b1;
                if (bus.st) begin
                    carrega = 1'b1;
                    proximo = CONVERTE;
                end
            end
            CONVERTE: begin
                passo = 1'b1;
                if (contador == ULTIMO) begin
                    ultimo  = 1'b1;
                    proximo = FIM;
                end
            end
            FIM: begin
                done_c  = 1'b1;
                proximo = OCIOSO;
            end
            default: proximo = OCIOSO;
        endcase
    end

    assign bus.done = done_c;
    assign bus.idle = idle_c;

    // State register; reset drops straight back to OCIOSO, aborting any
    // conversion in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    // Shift register and step counter. binario is only looked at on the
    // accepting edge; afterwards the register evolves on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            desloc   <= '0;
            contador <= '0;
        end else if (carrega) begin
            desloc   <= {{(4*DIGITOS){1'b0}}, bus.binario};
            contador <= '0;
        end else if (passo) begin
            desloc   <= deslocado;
            contador <= contador + CW'(1);
        end
    end

    // Digit registers keep the previous result until a conversion finishes;
    // they are deliberately not cleared when a new start is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.centena <= '0;
            bus.dezena  <= '0;
            bus.unidade <= '0;
        end else if (ultimo) begin
            bus.centena <= deslocado[LARGURA + 8 +: 4];
            bus.dezena  <= deslocado[LARGURA + 4 +: 4];
            bus.unidade <= deslocado[LARGURA     +: 4];
        end
    end

endmodule

// File: tb/tb_conversor_bcd.sv
// tb_conversor_bcd
// Directed bench for conversor_bcd: reset values, latency, digit results for
// hand-converted values, ignored starts, async reset and abort.
module tb_conversor_bcd;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    conversor_bcd_if bus ();

    conversor_bcd dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10 ns clock, active edge is posedge; outputs sampled on negedge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something upstream never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] digitos();
        return {20'd0, bus.centena, bus.dezena, bus.unidade};
    endfunction

    // Pulse st for one accepting edge with the given value on binario.
    task automatic applyStimulus(input logic [8:0] valor);
        @(negedge clk);
        bus.binario = valor;
        bus.st      = 1'b1;
        @(posedge clk);
        #1;
        bus.st = 1'b0;
    endtask

    // Count negedges after acceptance until done is seen (bounded).
    task automatic waitDone(output int n);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done) begin
                n = k;
                return;
            end
        end
    endtask

    // Full conversion with latency, digit and handshake checks.
    task automatic converte(input string tag, input logic [8:0] valor, input logic [11:0] esperado);
        int n;
        applyStimulus(valor);
        waitDone(n);
        checkOutput({tag, "_lat"}, n, 10);
        checkOutput({tag, "_dig"}, digitos(), {20'd0, esperado});
        checkOutput({tag, "_idle_low"}, bus.idle, 1'b0);
        @(negedge clk);
        checkOutput({tag, "_done_off"}, bus.done, 1'b0);
        checkOutput({tag, "_idle_back"}, bus.idle, 1'b1);
    endtask

    initial begin
        int n;
        int ndone;
        int primeiro;
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        bus.st      = 1'b0;
        bus.binario = '0;

        // Reset state.
        #23;
        checkOutput("rst_dig", digitos(), 32'h000);
        checkOutput("rst_idle", bus.idle, 1'b1);
        checkOutput("rst_done", bus.done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic conversions.
        converte("c143", 9'd143, 12'h143);

        // Second conversion: old digits must persist until the new done.
        applyStimulus(9'd105);
        repeat (5) @(negedge clk);
        checkOutput("c105_hold", digitos(), 32'h143);
        waitDone(n);
        checkOutput("c105_lat", n, 5);
        checkOutput("c105_dig", digitos(), 32'h105);
        @(negedge clk);

        // Boundaries.
        converte("c0", 9'd0, 12'h000);
        converte("c511", 9'd511, 12'h511);
        converte("c99", 9'd99, 12'h099);
        converte("c100", 9'd100, 12'h100);

        // st pulses and binario change during CONVERTE are ignored.
        applyStimulus(9'd200);
        ndone    = 0;
        primeiro = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 3 || k == 5) begin
                bus.st      = 1'b1;
                bus.binario = 9'd7;
            end else begin
                bus.st = 1'b0;
            end
            if (bus.done) begin
                ndone++;
                if (primeiro == 0) primeiro = k;
            end
        end
        checkOutput("ign_ndone", ndone, 1);
        checkOutput("ign_lat", primeiro, 10);
        checkOutput("ign_dig", digitos(), 32'h200);

        // Asynchronous reset mid-cycle, away from any clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_dig", digitos(), 32'h000);
        checkOutput("arst_idle", bus.idle, 1'b1);
        checkOutput("arst_done", bus.done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Abort: reset while the 5th step is pending.
        converte("c77", 9'd77, 12'h077);
        applyStimulus(9'd300);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_dig", digitos(), 32'h000);
        checkOutput("abort_idle", bus.idle, 1'b1);
        ndone = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 3) rst_n = 1'b1;
            if (bus.done) ndone++;
        end
        checkOutput("abort_ndone", ndone, 0);
        checkOutput("abort_dig_after", digitos(), 32'h000);
        converte("c225", 9'd225, 12'h225);

        // st held high: back-to-back conversions every 11 cycles.
        @(negedge clk);
        bus.binario = 9'd42;
        bus.st      = 1'b1;
        waitDone(n);
        checkOutput("cont_first", n, 10);
        waitDone(n);
        bus.st = 1'b0;
        checkOutput("cont_spacing", n, 11);
        checkOutput("cont_dig", digitos(), 32'h042);
        checkOutput("cont_excl", bus.idle, 1'b0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
